uart_line_rx: RTL
=================

# uart_line_rx

Receive-side line assembler for the UART string path. It consumes single-byte strobes from the byte-level UART receiver and accumulates them into a fixed-width string buffer. On a CR LF terminator it presents the completed line, its length and an overflow flag with a one-cycle done pulse. It is the receive counterpart of the string transmit path and feeds command parsers that compare received lines against string constants.

## Interface
- MAX_LEN, 16: buffer capacity in bytes, 1..255.
- TIMEOUT_CYC, 8680: idle cycles between bytes after which an open frame is aborted. The default is about 2 character times at 50 MHz, 115200 baud.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- rx_byte  in  8  received byte from the byte-level UART receiver.
- rx_byte_valid  in  1  one-cycle strobe qualifying rx_byte; may be high on consecutive cycles.
- rx_string  out  MAX_LEN*8  last completed line, right-aligned:
  - last data byte is at [7:0], first data byte at [rx_length*8-1 -: 8];
  - unused upper bytes are 0.
- rx_length  out  8  number of data bytes in rx_string, 0..MAX_LEN.
- rx_overflow  out  1  the completed line had more than MAX_LEN data bytes; excess bytes were dropped.
- rx_done  out  1  one-cycle pulse; rx_string, rx_length and rx_overflow are updated in the same cycle.
- rx_busy  out  1  a frame is open (state != IDLE).
- rx_timeout  out  1  one-cycle pulse when an open frame is aborted by timeout.

## Operation
- Data byte: any byte other than CR (0x0D) or LF (0x0A).
- Internal shift buffer:
  - on an accepted data byte with count < MAX_LEN: buf <= {buf[MAX_LEN*8-9:0], rx_byte}; count++;
  - on a data byte with count == MAX_LEN: byte dropped, overflow flag set, buffer unchanged.
- States:
  - IDLE:
    - data byte: clear buffer, count and overflow flag, store the byte, go to RECV;
    - CR: go to GOT_CR with count 0;
    - LF: ignored, stay in IDLE.
  - RECV:
    - data byte: store it, stay in RECV;
    - CR: go to GOT_CR;
    - LF alone: ignored, stay in RECV.
  - GOT_CR:
    - LF: terminate the line (see below), go to IDLE;
    - CR: stay in GOT_CR; the earlier CR is discarded;
    - data byte: the lone CR is discarded, the byte is stored as a normal data byte, go to RECV.
- Terminating a line:
  - if count > 0: copy buffer to rx_string, count to rx_length and the overflow flag to rx_overflow, and pulse rx_done;
  - if count == 0 (empty line): no rx_done and outputs unchanged.
- Timeout:
  - an idle counter clears on every rx_byte_valid and increments every cycle in RECV or GOT_CR;
  - when it reaches TIMEOUT_CYC-1, pulse rx_timeout, discard the frame and go to IDLE;
  - outputs keep the previous line.
- rx_string, rx_length and rx_overflow hold their values until the next rx_done.
- The output registers are separate from the shift buffer, so a new frame never disturbs presented data.

## Timing
- Reset values: all outputs 0; state IDLE; internal buffer, count, overflow flag and idle counter 0.
- Reset asserted mid-frame discards the frame immediately; no rx_done and no rx_timeout are issued.
- Throughput: one byte per cycle, with no stall and no backpressure.
- rx_byte_valid is sampled every cycle, including the cycle of an rx_done pulse.
- Latency: rx_done and the updated outputs appear in the cycle after the sys_clk edge that samples the terminating LF.
- A data byte arriving in the cycle immediately after that LF opens a new frame normally; rx_done still pulses for the previous line.
- rx_busy rises the cycle after the first accepted byte of a frame. It falls the same cycle rx_done or rx_timeout asserts, or the cycle after an empty-line LF.
- rx_timeout: a frame whose last byte was sampled at cycle t, with no further bytes, asserts rx_timeout at cycle t+TIMEOUT_CYC.
- A byte arriving in the very cycle the counter hits TIMEOUT_CYC-1 takes priority: the counter clears and no timeout occurs.

## Test plan
- Send "abc\r\n" as back-to-back strobes -> one rx_done pulse, one cycle after the LF:
  - rx_length = 3;
  - rx_string[23:0] = 0x616263, upper bits 0;
  - rx_overflow = 0;
  - rx_busy is low after the pulse.
- With MAX_LEN = 16, send 20 bytes 0x41..0x54 then CR LF -> rx_done with:
  - rx_length = 16;
  - rx_overflow = 1;
  - rx_string bytes 0x41..0x50, with 0x50 at [7:0].
- Send "\r\n" alone, then "x\ry\r\n" -> the empty line produces no rx_done; the second line yields:
  - rx_length = 2;
  - rx_string[15:0] = 0x7879 (lone CR dropped).
- Send "ab", then wait TIMEOUT_CYC cycles -> rx_timeout pulses once, rx_busy falls, and rx_string, rx_length and rx_done are unchanged from the prior line.
- Assert sys_rst mid-frame after "ab", release, then send "z\r\n" -> no done before the reset; afterwards rx_length = 1 and rx_string[7:0] = 0x7A.
- Send "hi\r\n" immediately followed in the next cycle by "ok\r\n" -> two rx_done pulses with values 0x6869 and 0x6F6B respectively, each of length 2.

Source files
------------

// File: rtl/uart_line_rx_if.sv
// Byte-in / line-out bundle for the UART line assembler.
// master: byte source and line consumer; slave: the assembler itself.
interface uart_line_rx_if #(
  parameter int unsigned MAX_LEN = 16
);

  logic [7:0]           rx_byte;
  logic                 rx_byte_valid;
  logic [MAX_LEN*8-1:0] rx_string;
  logic [7:0]           rx_length;
  logic                 rx_overflow;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 rx_timeout;

  modport master (
    output rx_byte,
    output rx_byte_valid,
    input  rx_string,
    input  rx_length,
    input  rx_overflow,
    input  rx_done,
    input  rx_busy,
    input  rx_timeout
  );

  modport slave (
    input  rx_byte,
    input  rx_byte_valid,
    output rx_string,
    output rx_length,
    output rx_overflow,
    output rx_done,
    output rx_busy,
    output rx_timeout
  );

endinterface

// File: rtl/uart_line_rx.sv
// Assembles received UART bytes into a right-aligned line buffer and presents
// each CR LF terminated line with its length and an overflow flag.
module uart_line_rx #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 8680
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  uart_line_rx_if.slave bus
);

  localparam int unsigned W  = MAX_LEN * 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]    MaxLen8     = 8'(MAX_LEN);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    ChCr        = 8'h0D;
  localparam logic [7:0]    ChLf        = 8'h0A;

  typedef enum logic [1:0] {StIdle, StRecv, StGotCr} state_e;

  state_e        r_state, w_state_nxt;
  logic [W-1:0]  r_buf, w_buf_nxt;
  logic [7:0]    r_count, w_count_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic [TW-1:0] r_idle, w_idle_nxt;
  logic [W-1:0]  r_string, w_string_nxt;
  logic [7:0]    r_length, w_length_nxt;
  logic          r_overflow, w_overflow_nxt;
  logic          r_done, w_done_nxt;
  logic          r_timeout, w_timeout_nxt;

  logic          w_is_cr, w_is_lf, w_is_data;
  logic [W-1:0]  w_shift;

  assign w_is_cr   = bus.rx_byte_valid && (bus.rx_byte == ChCr);
  assign w_is_lf   = bus.rx_byte_valid && (bus.rx_byte == ChLf);
  assign w_is_data = bus.rx_byte_valid && !w_is_cr && !w_is_lf;

  // Buffer shifted left by one byte with the new byte entering at [7:0]
  if (MAX_LEN > 1) begin : g_shift
    assign w_shift = {r_buf[W-9:0], bus.rx_byte};
  end else begin : g_single
    assign w_shift = bus.rx_byte;
  end

  // State register plus buffer, idle counter and presented-line registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= StIdle;
      r_buf      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_idle     <= '0;
      r_string   <= '0;
      r_length   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_count    <= w_count_nxt;
      r_ovf      <= w_ovf_nxt;
      r_idle     <= w_idle_nxt;
      r_string   <= w_string_nxt;
      r_length   <= w_length_nxt;
      r_overflow <= w_overflow_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state logic: framing, byte storage, termination and timeout
  always_comb begin
    w_state_nxt    = r_state;
    w_buf_nxt      = r_buf;
    w_count_nxt    = r_count;
    w_ovf_nxt      = r_ovf;
    w_idle_nxt     = r_idle;
    w_string_nxt   = r_string;
    w_length_nxt   = r_length;
    w_overflow_nxt = r_overflow;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_idle_nxt = '0;
        if (w_is_data) begin
          w_buf_nxt      = '0;
          w_buf_nxt[7:0] = bus.rx_byte;
          w_count_nxt    = 8'd1;
          w_ovf_nxt      = 1'b0;
          w_state_nxt    = StRecv;
        end else if (w_is_cr) begin
          w_buf_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = StGotCr;
        end
      end

      StRecv, StGotCr: begin
        // Any strobe restarts the idle count, so a byte on the last cycle wins
        if (bus.rx_byte_valid) begin
          w_idle_nxt = '0;
        end else if (r_idle == TimeoutLast) begin
          w_idle_nxt    = '0;
          w_timeout_nxt = 1'b1;
          w_buf_nxt     = '0;
          w_count_nxt   = '0;
          w_ovf_nxt     = 1'b0;
          w_state_nxt   = StIdle;
        end else begin
          w_idle_nxt = r_idle + TW'(1);
        end

        if (w_is_data) begin
          if (r_count < MaxLen8) begin
            w_buf_nxt   = w_shift;
            w_count_nxt = r_count + 8'd1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
          w_state_nxt = StRecv;
        end else if (w_is_cr) begin
          w_state_nxt = StGotCr;
        end else if (w_is_lf && (r_state == StGotCr)) begin
          // Empty lines close silently and leave the presented line alone
          if (r_count != 8'd0) begin
            w_string_nxt   = r_buf;
            w_length_nxt   = r_count;
            w_overflow_nxt = r_ovf;
            w_done_nxt     = 1'b1;
          end
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign bus.rx_string   = r_string;
  assign bus.rx_length   = r_length;
  assign bus.rx_overflow = r_overflow;
  assign bus.rx_done     = r_done;
  assign bus.rx_timeout  = r_timeout;
  assign bus.rx_busy     = (r_state != StIdle);

endmodule
